// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin shared-bus block.
// Holds the arbiter state encoding and the width helper used to size
// the owner index and destination select fields.
package bus_pkg;

  // Arbiter states: no owner, or exactly one owner driving beats
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } bus_state_t;

  // Index width for a count of items, never narrower than one bit so a
  // single destination still gets a real select field
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority pick.
// Grants the first requester at an index at or above ptr; if none exists
// it wraps and grants the lowest requester overall.
module rr_pick #(
  parameter int SRC = 4,
  parameter int SW  = 2
) (
  input  logic [SRC-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic [SRC-1:0] gnt,
  output logic [SW-1:0]  idx,
  output logic           valid
);

  logic [SRC-1:0] masked;
  logic [SRC-1:0] pool;

  // Keep only requesters at or above the pointer (the "ahead" half)
  always_comb begin
    masked = '0;
    for (int i = 0; i < SRC; i++) begin
      masked[i] = req[i] && (SW'(i) >= ptr);
    end
  end

  assign pool  = (|masked) ? masked : req;
  assign valid = |req;

  // Lowest set bit of the chosen pool wins; scanning downward lets the
  // lowest index overwrite any higher one
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = SRC - 1; i >= 0; i--) begin
      if (pool[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = SW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Shared registered bus with round-robin ownership and destination registers.
// One owner at a time transfers one word per beat; bursts end on last, on
// MAX_BURST beats, or when the owner drops req. Every ownership change
// passes through one IDLE turnaround cycle.
// Optional feature macro: BUS_LOCK_EN adds a per-source lock input that
// suppresses the MAX_BURST release for the current owner.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int N         = 8,
  parameter int SRC       = 4,
  parameter int DST       = 4,
  parameter int MAX_BURST = 4,
  localparam int SW       = clog2_min1(SRC),
  localparam int DW       = clog2_min1(DST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SRC-1:0]   req,
  input  logic [SRC-1:0]   last,
  input  logic [SRC*N-1:0] data_in,
  input  logic [SRC*DW-1:0] dst_sel,
`ifdef BUS_LOCK_EN
  input  logic [SRC-1:0]   lock,
`endif
  output logic [SRC-1:0]   gnt,
  output logic [SW-1:0]    owner,
  output logic [N-1:0]     bus,
  output logic             bus_valid,
  output logic [DST*N-1:0] data_out,
  output logic [DST-1:0]   out_valid
);

  // Beat counter must be able to hold MAX_BURST itself when saturating
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [SW-1:0] SRC_TOP    = SW'(SRC - 1);

  bus_state_t     state, state_next;
  logic [SW-1:0]  ptr, ptr_next;
  logic [SW-1:0]  owner_next;
  logic [SRC-1:0] gnt_next;
  logic [CW-1:0]  beat_cnt, beat_cnt_next;
  logic [DW-1:0]  bus_dst;

  logic [SRC-1:0] pick_gnt;
  logic [SW-1:0]  pick_idx;
  logic           pick_valid;

  logic           owner_req;
  logic           owner_last;
  logic           owner_lock;
  logic [N-1:0]   owner_data;
  logic [DW-1:0]  owner_dst;

  logic           beat;
  logic           burst_full;
  logic           release_own;

  rr_pick #(
    .SRC (SRC),
    .SW  (SW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Route the current owner's request, last, lock, word and target to
  // single signals so the FSM and bus logic never see other sources
  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_lock = 1'b0;
    owner_data = '0;
    owner_dst  = '0;
    for (int i = 0; i < SRC; i++) begin
      if (owner == SW'(i)) begin
        owner_req  = req[i];
        owner_last = last[i];
        owner_data = data_in[i*N +: N];
        owner_dst  = dst_sel[i*DW +: DW];
`ifdef BUS_LOCK_EN
        owner_lock = lock[i];
`endif
      end
    end
  end

  // A beat is any owned cycle where the owner still requests; the burst
  // is full when this beat would be number MAX_BURST or beyond
  assign beat       = (state == OWN) && owner_req;
  assign burst_full = (beat_cnt >= BURST_LAST);

  // Release on a request drop, a last beat, or a full burst not held by lock
  assign release_own = (state == OWN) &&
                       (!owner_req || owner_last || (burst_full && !owner_lock));

  // Next-state logic for ownership, round-robin pointer and beat count
  always_comb begin
    state_next    = state;
    gnt_next      = gnt;
    owner_next    = owner;
    ptr_next      = ptr;
    beat_cnt_next = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = OWN;
          gnt_next   = pick_gnt;
          owner_next = pick_idx;
        end
      end
      OWN: begin
        if (release_own) begin
          state_next    = IDLE;
          gnt_next      = '0;
          ptr_next      = (owner == SRC_TOP) ? '0 : owner + 1'b1;
          beat_cnt_next = '0;
        end else if (beat && (beat_cnt != BURST_MAX)) begin
          beat_cnt_next = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        gnt_next      = '0;
        beat_cnt_next = '0;
      end
    endcase
  end

  // Arbiter state register; reset aborts any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      owner    <= owner_next;
      ptr      <= ptr_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  // Bus register: load the owner's word on a beat, otherwise hold it and
  // drop the valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus       <= '0;
      bus_valid <= 1'b0;
      bus_dst   <= '0;
    end else if (beat) begin
      bus       <= owner_data;
      bus_valid <= 1'b1;
      bus_dst   <= owner_dst;
    end else begin
      bus_valid <= 1'b0;
    end
  end

  // Destination registers capture the bus word addressed to them; an
  // out-of-range target matches no register and is silently dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= '0;
    end else begin
      out_valid <= '0;
      for (int i = 0; i < DST; i++) begin
        if (bus_valid && (bus_dst == DW'(i))) begin
          data_out[i*N +: N] <= bus;
          out_valid[i]       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Parametrised shared-bus block with one registered bus, `SRC` sources and `DST` destination registers. A round-robin arbiter grants ownership to one source at a time, and the owner transfers one word per beat. Each destination register captures the bus word addressed to it. It replaces the fixed two-source, select-driven bus for multi-master datapaths, and adds burst ownership, fairness and a turnaround cycle between owners.

## Interface
Parameters:
- `N`, 8: data width.
- `SRC`, 4: number of sources (≥2).
- `DST`, 4: number of destinations (≥1).
- `MAX_BURST`, 4: maximum beats per ownership (≥1).
- Derived: `SW = $clog2(SRC)`, `DW = max(1,$clog2(DST))`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in SRC: per-source request / beat-valid.
- `last` in SRC: marks the final beat of a source's burst.
- `data_in` in SRC*N: source words, source i at `[i*N +: N]`.
- `dst_sel` in SRC*DW: target destination per source.
- `gnt` out SRC: one-hot ownership grant, or all zero.
- `owner` out SW: index of the current owner, valid while `|gnt`.
- `bus` out N: registered bus word.
- `bus_valid` out 1: `bus` holds a beat this cycle.
- `data_out` out DST*N: destination registers.
- `out_valid` out DST: one-cycle capture pulse per destination.

## Operation
States:
- IDLE: no owner.
- OWN: one owner.

Round-robin pointer `ptr` (SW bits), reset 0.

- **IDLE:** if `|req`, choose the first requester at index ≥`ptr`, wrapping modulo SRC. Set `gnt`/`owner` and go to OWN. Otherwise stay in IDLE.
- **Beat:** any OWN cycle with `req[owner]`=1. At that edge:
  - `bus` ← owner's `data_in`;
  - `bus_valid` ← 1;
  - internal `bus_dst` ← owner's `dst_sel`;
  - beat counter increments.
- **Non-beat cycles:** `bus_valid` ← 0 and `bus` holds its last value.
- **Release from OWN to IDLE** on the first of:
  - a beat with `last[owner]`=1;
  - a beat that is beat number MAX_BURST;
  - any OWN cycle with `req[owner]`=0.
- **On release:** `gnt` ← 0, `ptr` ← owner+1 (wrapping SRC−1→0), beat counter ← 0.
- **Destination capture:** on a cycle where `bus_valid`=1 and `bus_dst` < DST, `data_out[bus_dst]` ← `bus` and `out_valid[bus_dst]` ← 1 for one cycle. Other destinations hold their value and their `out_valid` is 0.
- **Out-of-range `dst_sel`** (≥DST): the beat still appears on `bus`, but no destination captures it and no `out_valid` pulses.
- **Non-owner requests** are ignored and never corrupt `bus`.

Reset values (all outputs): `gnt`=0, `owner`=0, `bus`=0, `bus_valid`=0, `data_out`=0, `out_valid`=0. Internally, state=IDLE, `ptr`=0, beat counter=0. Asserting reset mid-burst aborts the burst immediately; the in-flight beat is lost.

## Timing
- `req` rises at edge k; `gnt` is visible after edge k+1.
- First beat is sampled at edge k+2, so `bus`/`bus_valid` are visible after k+2 and `data_out`/`out_valid` after k+3.
- Bus latency is 1 cycle from beat to `bus`; destination latency is 2 cycles from beat to `data_out`.
- Back-to-back beats from the same owner give a throughput of one word per cycle.
- Ownership change always passes through one IDLE cycle with `gnt`=0. This is the turnaround cycle, so there is at least 1 dead bus cycle between owners.
- `last` together with `req` at the MAX_BURST-th beat counts as a single release.
- A source that deasserts `req` after release and reasserts it in the IDLE cycle competes normally, but the pointer has already moved past it.

## Configuration
- `BUS_LOCK_EN`:
  - When defined, adds input port `lock` (SRC bits). While `lock[owner]`=1, the MAX_BURST release is suppressed and the beat counter saturates at MAX_BURST. Release then happens only on `last` or on `req` drop.
  - When undefined, the port is absent and the MAX_BURST limit always applies.

## Structure
- Shared package `bus_pkg`:
  - state enum `{IDLE, OWN}`;
  - constants `SW`/`DW` helper functions (clog2 with min 1).
- Sub-module `rr_pick`: combinational round-robin priority pick.
  - Inputs: `req[SRC]`, `ptr`.
  - Outputs: one-hot grant and index.
  - Instanced once; arbiter FSM, bus register and destination registers live in the top.

## Test plan
- Reset mid-burst: source 0 bursting `8'hA2` to dst 1, `rst_n`=0 → all outputs 0 asynchronously; after release, `gnt`=0 and `ptr`=0.
- Single beat: `req[1]`=1, `last[1]`=1, `data_in[1]`=`8'h9C`, `dst_sel[1]`=2 → `gnt`=`4'b0010` at +1, `bus`=9C at +2, `data_out[2]`=9C and `out_valid`=`4'b0100` at +3, `gnt`=0 at +3.
- Fairness: `req`=`4'b1111` held, no `last` → owners 0,1,2,3,0, each with 4 beats (MAX_BURST), 1 idle cycle between owners.
- Early release: source 2 drops `req` after 2 beats (`8'h54`, `8'h90` to dst 0) → `data_out[0]`=90, next grant goes to source 3.
- Out-of-range destination: DST=3, `dst_sel`=3, `data_in`=`8'h11` → `bus`=11, `bus_valid`=1, `out_valid`=0, `data_out` unchanged.
- With `BUS_LOCK_EN`: `lock[0]`=1 and 6 beats with `last` on the 6th → 6 consecutive beats from source 0, then release; source 1 (already requesting) is granted after the idle cycle.
